// File: rtl/dir_cmd_sched.sv
// Direction command scheduler: edge-detected keyboard directions queue up and are applied one per game tick.
// Optional build macro DIR_SCHED_REVERSE_FILTER_EN drops commands that reverse the last accepted direction.
module dir_cmd_sched #(
  parameter int         DEPTH    = 4,
  parameter logic [2:0] INIT_DIR = 3'd4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] kb_code,
  input  logic       en,
  input  logic       tick,
  output logic [2:0] dir_out,
  output logic       dir_valid,
  output logic [3:0] q_count,
  output logic       overflow
);
  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         STAGES = 1;
  localparam logic [3:0] FULL   = 4'(DEPTH);

  typedef enum logic {STOP, RUN} state_t;

  state_t                  state;
  logic [2:0]              kb_prev;
  logic [2:0]              last_acc;
  logic [AW-1:0]           head, tail;
  logic [DEPTH-1:0][2:0]   q;
  logic [STAGES:0]         vld_pipe;

  logic active, kb_ok, new_cmd, rev, cand, full, do_pop, do_push, drop_full;

`ifdef DIR_SCHED_REVERSE_FILTER_EN
  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      3'd1:    opposite = 3'd2;
      3'd2:    opposite = 3'd1;
      3'd3:    opposite = 3'd4;
      3'd4:    opposite = 3'd3;
      default: opposite = 3'd0;
    endcase
  endfunction
  assign rev = (opposite(kb_code) == last_acc);
`else
  assign rev = 1'b0;
`endif

  // Commands only count while running with en held high; the RUN->STOP cycle is a flush.
  assign active    = (state == RUN) && en;
  assign kb_ok     = (kb_code >= 3'd1) && (kb_code <= 3'd4);
  assign new_cmd   = active && kb_ok && (kb_code != kb_prev);
  assign cand      = new_cmd && (kb_code != last_acc) && !rev;
  assign full      = (q_count == FULL);
  assign do_pop    = active && tick && (q_count != 4'd0);
  assign do_push   = cand && (!full || do_pop);
  assign drop_full = cand && full && !do_pop;

  assign vld_pipe[0] = active && tick;
  assign dir_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!clr) begin
      state            <= STOP;
      dir_out          <= INIT_DIR;
      last_acc         <= INIT_DIR;
      kb_prev          <= 3'd0;
      head             <= '0;
      tail             <= '0;
      q                <= '0;
      q_count          <= 4'd0;
      overflow         <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // Invalid codes leave the edge history alone so a held key is not re-armed.
      if (kb_code <= 3'd4) kb_prev <= kb_code;

      case (state)
        STOP: if (en) state <= RUN;
        RUN:  if (!en) state <= STOP;
        default: state <= STOP;
      endcase

      if (state == RUN && !en) begin
        head    <= '0;
        tail    <= '0;
        q_count <= 4'd0;
      end else begin
        if (do_pop) begin
          dir_out <= q[head];
          head    <= head + 1'b1;
        end
        if (do_push) begin
          q[tail]  <= kb_code;
          tail     <= tail + 1'b1;
          last_acc <= kb_code;
        end
        q_count <= q_count + 4'(do_push) - 4'(do_pop);
      end

      if (drop_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dir_cmd_sched.sv
// Directed bench for dir_cmd_sched: queueing, edge detect, overflow, flush and reset behaviour.
module tb_dir_cmd_sched;
  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] kb_code;
  logic       en;
  logic       tick;
  logic [2:0] dir_out;
  logic       dir_valid;
  logic [3:0] q_count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  dir_cmd_sched #(.DEPTH(4), .INIT_DIR(3'd4)) dut (
    .clk(clk), .clr(clr), .kb_code(kb_code), .en(en), .tick(tick),
    .dir_out(dir_out), .dir_valid(dir_valid), .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    clr = 1'b0; en = 1'b0; kb_code = 3'd0; tick = 1'b0;
    cyc(); cyc();
    clr = 1'b1; en = 1'b1;
    cyc();
  endtask

  task automatic press(input logic [2:0] c);
    kb_code = c;
    cyc();
  endtask

  task automatic test_reset();
    clr = 1'b0; en = 1'b0; kb_code = 3'd0; tick = 1'b0;
    cyc(); cyc();
    total++; if (dir_out !== 3'd4) begin bad++; $display("FAIL reset_dir got=%0d exp=4", dir_out); end
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", dir_valid); end
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", q_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
  endtask

  task automatic test_basic();
    start_run();
    press(3'd1);
    total++; if (q_count !== 4'd1) begin bad++; $display("FAIL basic_push_cnt got=%0d exp=1", q_count); end
    kb_code = 3'd0; tick = 1'b1;
    cyc();
    tick = 1'b0;
    total++; if (dir_out !== 3'd1) begin bad++; $display("FAIL basic_dir got=%0d exp=1", dir_out); end
    total++; if (dir_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", dir_valid); end
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL basic_pop_cnt got=%0d exp=0", q_count); end
    cyc();
    total++; if (dir_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b exp=0", dir_valid); end
  endtask

  task automatic test_hold();
    start_run();
    kb_code = 3'd1;
    for (int i = 0; i < 10; i++) cyc();
    total++; if (q_count !== 4'd1) begin bad++; $display("FAIL hold_cnt got=%0d exp=1", q_count); end
    // Release and re-press the same code: equals last accepted, so dropped
    press(3'd0);
    press(3'd1);
    total++; if (q_count !== 4'd1) begin bad++; $display("FAIL same_as_last_cnt got=%0d exp=1", q_count); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_seq [4];
    exp_seq = '{3'd1, 3'd3, 3'd1, 3'd3};
    start_run();
    press(3'd1); press(3'd3); press(3'd1); press(3'd3);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%0b exp=0", overflow); end
    press(3'd1);
    total++; if (q_count !== 4'd4) begin bad++; $display("FAIL ovf_cnt got=%0d exp=4", q_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    kb_code = 3'd0; tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (dir_out !== exp_seq[i] || dir_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain[%0d] got=%0d/%0b exp=%0d/1", i, dir_out, dir_valid, exp_seq[i]); end
    end
    // Tick on an empty queue still pulses valid and holds the direction
    cyc();
    tick = 1'b0;
    total++; if (dir_out !== 3'd3 || dir_valid !== 1'b1) begin bad++; $display("FAIL empty_tick got=%0d/%0b exp=3/1", dir_out, dir_valid); end
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL ovf_drained_cnt got=%0d exp=0", q_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [2:0] exp_seq [4];
    exp_seq = '{3'd3, 3'd1, 3'd3, 3'd2};
    start_run();
    press(3'd1); press(3'd3); press(3'd1); press(3'd3);
    kb_code = 3'd2; tick = 1'b1;
    cyc();
    total++; if (dir_out !== 3'd1) begin bad++; $display("FAIL fullpp_dir got=%0d exp=1", dir_out); end
    total++; if (q_count !== 4'd4) begin bad++; $display("FAIL fullpp_cnt got=%0d exp=4", q_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%0b exp=0", overflow); end
    kb_code = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (dir_out !== exp_seq[i]) begin bad++; $display("FAIL fullpp_drain[%0d] got=%0d exp=%0d", i, dir_out, exp_seq[i]); end
    end
    tick = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    start_run();
    kb_code = 3'd1; tick = 1'b1;
    cyc();
    total++; if (dir_out !== 3'd4 || dir_valid !== 1'b1) begin bad++; $display("FAIL emptypp_dir got=%0d/%0b exp=4/1", dir_out, dir_valid); end
    total++; if (q_count !== 4'd1) begin bad++; $display("FAIL emptypp_cnt got=%0d exp=1", q_count); end
    kb_code = 3'd0;
    cyc();
    tick = 1'b0;
    total++; if (dir_out !== 3'd1) begin bad++; $display("FAIL emptypp_next got=%0d exp=1", dir_out); end
  endtask

  task automatic test_reverse();
    start_run();
    press(3'd3);
`ifdef DIR_SCHED_REVERSE_FILTER_EN
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL rev_cnt got=%0d exp=0", q_count); end
`else
    total++; if (q_count !== 4'd1) begin bad++; $display("FAIL rev_cnt got=%0d exp=1", q_count); end
`endif
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rev_ovf got=%0b exp=0", overflow); end
  endtask

  task automatic test_invalid_history();
    start_run();
    press(3'd1); press(3'd3); press(3'd1); press(3'd3);
    press(3'd2);
    total++; if (q_count !== 4'd4 || overflow !== 1'b1) begin bad++; $display("FAIL inv_full got=%0d/%0b exp=4/1", q_count, overflow); end
    kb_code = 3'd5; tick = 1'b1;
    cyc();
    tick = 1'b0;
    total++; if (q_count !== 4'd3) begin bad++; $display("FAIL inv_ignored got=%0d exp=3", q_count); end
    // History still holds 2, so returning to 2 is not a new command
    press(3'd2);
    total++; if (q_count !== 4'd3) begin bad++; $display("FAIL inv_history got=%0d exp=3", q_count); end
  endtask

  task automatic test_stop_flush();
    start_run();
    press(3'd1); press(3'd3);
    kb_code = 3'd0;
    total++; if (q_count !== 4'd2) begin bad++; $display("FAIL stop_pre_cnt got=%0d exp=2", q_count); end
    en = 1'b0;
    cyc();
    total++; if (q_count !== 4'd0 || dir_out !== 3'd4) begin bad++; $display("FAIL stop_flush got=%0d/%0d exp=0/4", q_count, dir_out); end
    tick = 1'b1;
    cyc();
    total++; if (dir_valid !== 1'b0 || dir_out !== 3'd4) begin bad++; $display("FAIL stop_tick got=%0b/%0d exp=0/4", dir_valid, dir_out); end
    tick = 1'b0;
    press(3'd2);
    total++; if (q_count !== 4'd0) begin bad++; $display("FAIL stop_kb got=%0d exp=0", q_count); end
  endtask

  task automatic test_midreset();
    start_run();
    press(3'd1); press(3'd3); press(3'd1); press(3'd3); press(3'd1);
    kb_code = 3'd2; tick = 1'b1; clr = 1'b0;
    cyc();
    total++; if (q_count !== 4'd0 || overflow !== 1'b0) begin bad++; $display("FAIL midrst_cnt got=%0d/%0b exp=0/0", q_count, overflow); end
    total++; if (dir_out !== 3'd4 || dir_valid !== 1'b0) begin bad++; $display("FAIL midrst_dir got=%0d/%0b exp=4/0", dir_out, dir_valid); end
    clr = 1'b1; tick = 1'b0; kb_code = 3'd0;
    cyc();
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; kb_code = 3'd0; tick = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_reverse();
    test_invalid_history();
    test_stop_flush();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
